// File: rtl/sprite_draw_sched_if.sv
// Draw-engine command bus: the scheduler drives start/coord/img and
// observes the engine's done level.
//
// Handshake: draw_start is a one-cycle command pulse qualifying draw_coord and
// draw_img. The engine drops draw_done the cycle after start. Later it raises
// draw_done as a level to signal completion. A low-to-high transition on
// draw_done after a start is the only completion indication.
interface sprite_draw_sched_if;
   logic        draw_start;
   logic [18:0] draw_coord;
   logic [7:0]  draw_img;
   logic        draw_done;

   modport master (
      output draw_start,
      output draw_coord,
      output draw_img,
      input  draw_done
   );

   modport slave (
      input  draw_start,
      input  draw_coord,
      input  draw_img,
      output draw_done
   );
endinterface

// File: rtl/sprite_draw_sched.sv
// Per-frame sprite scheduler: holds the sprite attribute table and, on each
// frame_start, issues one draw command per valid entry in index order.
// Each command waits for the engine's done edge or a watchdog before moving on.
module sprite_draw_sched #(
   parameter int NUM_SPRITES = 16,
   parameter int IDX_W       = 4,
   parameter int TIMEOUT     = 2048,
   parameter int TO_W        = 12
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_start,
   input  logic                tbl_we,
   input  logic [IDX_W-1:0]    tbl_waddr,
   input  logic                tbl_wvalid,
   input  logic [18:0]         tbl_wcoord,
   input  logic [7:0]          tbl_wimg,
   sprite_draw_sched_if.master draw,
   output logic                busy,
   output logic                frame_done,
   output logic [IDX_W:0]      sprites_drawn,
   output logic                timeout_err,
   output logic                frame_overrun,
   input  logic                err_clr,
   output logic [2:0]          dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SCAN  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SPRITES - 1);
   localparam logic [IDX_W-1:0] ONE_IDX   = IDX_W'(1);
   localparam logic [IDX_W:0]   ONE_CNT   = (IDX_W+1)'(1);
   localparam logic [TO_W-1:0]  TIMER_END = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0]  ONE_TMR   = TO_W'(1);

   // Sprite attribute table
   logic [NUM_SPRITES-1:0] valid_q, valid_d;
   logic [18:0]            coord_q [NUM_SPRITES];
   logic [18:0]            coord_d [NUM_SPRITES];
   logic [7:0]             img_q   [NUM_SPRITES];
   logic [7:0]             img_d   [NUM_SPRITES];

   // Sweep control and registered outputs
   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [TO_W-1:0]   timer_q, timer_d;
   logic              done_q, done_d;
   logic              draw_start_q, draw_start_d;
   logic [18:0]       draw_coord_q, draw_coord_d;
   logic [7:0]        draw_img_q, draw_img_d;
   logic              busy_q, busy_d;
   logic              frame_done_q, frame_done_d;
   logic [IDX_W:0]    sprites_q, sprites_d;
   logic              timeout_err_q, timeout_err_d;
   logic              overrun_q, overrun_d;
   logic              done_rise;
   logic              to_set, ov_set;

   // Table write port: accepted in every state, one entry per cycle
   always_comb begin
      valid_d = valid_q;
      coord_d = coord_q;
      img_d   = img_q;
      if (tbl_we) begin
         valid_d[tbl_waddr] = tbl_wvalid;
         coord_d[tbl_waddr] = tbl_wcoord;
         img_d[tbl_waddr]   = tbl_wimg;
      end
   end

   // Table storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            coord_q[i] <= '0;
            img_q[i]   <= '0;
         end
      end else begin
         valid_q <= valid_d;
         coord_q <= coord_d;
         img_q   <= img_d;
      end
   end

   // Only a fresh low-to-high edge of done counts; a level left high from an
   // earlier draw is therefore ignored.
   assign done_rise = draw.draw_done & ~done_q;

   // Sweep FSM next-state, watchdog, counters and sticky error flags
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      timer_d      = timer_q;
      done_d       = draw.draw_done;
      draw_start_d = 1'b0;
      draw_coord_d = draw_coord_q;
      draw_img_d   = draw_img_q;
      frame_done_d = 1'b0;
      sprites_d    = sprites_q;
      to_set       = 1'b0;
      ov_set       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               state_d   = S_SCAN;
               idx_d     = '0;
               sprites_d = '0;
            end
         end
         S_SCAN: begin
            if (valid_q[idx_q]) begin
               state_d      = S_ISSUE;
               draw_start_d = 1'b1;
               draw_coord_d = coord_q[idx_q];
               draw_img_d   = img_q[idx_q];
            end else if (idx_q == LAST_IDX) begin
               state_d      = S_DONE;
               frame_done_d = 1'b1;
            end else begin
               idx_d = idx_q + ONE_IDX;
            end
         end
         S_ISSUE: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            timer_d = timer_q + ONE_TMR;
            if (done_rise || (timer_q == TIMER_END)) begin
               // Completion wins over the watchdog in the same cycle
               if (done_rise) begin
                  sprites_d = sprites_q + ONE_CNT;
               end else begin
                  to_set = 1'b1;
               end
               if (idx_q == LAST_IDX) begin
                  state_d      = S_DONE;
                  frame_done_d = 1'b1;
               end else begin
                  idx_d   = idx_q + ONE_IDX;
                  state_d = S_SCAN;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (frame_start && (state_q != S_IDLE)) begin
         ov_set = 1'b1;
      end

      busy_d        = (state_d != S_IDLE);
      timeout_err_d = to_set ? 1'b1 : (err_clr ? 1'b0 : timeout_err_q);
      overrun_d     = ov_set ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
   end

   // Sweep state and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         timer_q       <= '0;
         done_q        <= 1'b0;
         draw_start_q  <= 1'b0;
         draw_coord_q  <= '0;
         draw_img_q    <= '0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         sprites_q     <= '0;
         timeout_err_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         timer_q       <= timer_d;
         done_q        <= done_d;
         draw_start_q  <= draw_start_d;
         draw_coord_q  <= draw_coord_d;
         draw_img_q    <= draw_img_d;
         busy_q        <= busy_d;
         frame_done_q  <= frame_done_d;
         sprites_q     <= sprites_d;
         timeout_err_q <= timeout_err_d;
         overrun_q     <= overrun_d;
      end
   end

   assign draw.draw_start = draw_start_q;
   assign draw.draw_coord = draw_coord_q;
   assign draw.draw_img   = draw_img_q;
   assign busy            = busy_q;
   assign frame_done      = frame_done_q;
   assign sprites_drawn   = sprites_q;
   assign timeout_err     = timeout_err_q;
   assign frame_overrun   = overrun_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_sprite_draw_sched.sv
// Bench for sprite_draw_sched: directed scenarios plus randomized sweeps.
// The reference is a table of attributes and the ordered list of draws it implies.
module tb_sprite_draw_sched;
   localparam int NUM_SPRITES = 16;
   localparam int IDX_W       = 4;
   localparam int TIMEOUT     = 2048;
   localparam int TO_W        = 12;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic             frame_start = 1'b0;
   logic             tbl_we      = 1'b0;
   logic [IDX_W-1:0] tbl_waddr   = '0;
   logic             tbl_wvalid  = 1'b0;
   logic [18:0]      tbl_wcoord  = '0;
   logic [7:0]       tbl_wimg    = '0;
   logic             err_clr     = 1'b0;
   logic             busy, frame_done, timeout_err, frame_overrun;
   logic [IDX_W:0]   sprites_drawn;
   logic [2:0]       dbg_state;

   sprite_draw_sched_if ifc ();

   sprite_draw_sched #(
      .NUM_SPRITES(NUM_SPRITES), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
   ) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start),
      .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wvalid(tbl_wvalid),
      .tbl_wcoord(tbl_wcoord), .tbl_wimg(tbl_wimg),
      .draw(ifc.master),
      .busy(busy), .frame_done(frame_done), .sprites_drawn(sprites_drawn),
      .timeout_err(timeout_err), .frame_overrun(frame_overrun),
      .err_clr(err_clr), .dbg_state(dbg_state)
   );

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_starts = 0;
   int          n_fdone  = 0;
   logic [26:0] exp_q[$];
   logic        mdl_valid [NUM_SPRITES];
   logic [18:0] mdl_coord [NUM_SPRITES];
   logic [7:0]  mdl_img   [NUM_SPRITES];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected draws of a sweep: every valid entry, lowest index first
   task automatic build_expected();
      exp_q.delete();
      for (int i = 0; i < NUM_SPRITES; i++)
         if (mdl_valid[i]) exp_q.push_back({mdl_coord[i], mdl_img[i]});
   endtask

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < NUM_SPRITES; i++) if (mdl_valid[i]) n++;
      return n;
   endfunction

   // Every draw command must match the head of the expected list
   always @(negedge clk) begin
      if (!rst && ifc.draw_start) begin
         logic [26:0] e;
         n_starts++;
         if (exp_q.size() == 0) begin
            check("unexpected_draw_start", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("draw_coord_img", {5'd0, ifc.draw_coord, ifc.draw_img}, {5'd0, e});
         end
      end
      if (!rst && frame_done) n_fdone++;
   end

   // ---------------- draw engine model ----------------
   // Drops done the cycle after start, raises it eng_delay cycles later and
   // leaves it high. An img of 0xEE never completes.
   int   eng_delay = 70;
   int   eng_cnt   = 0;
   logic eng_armed = 1'b0;
   logic eng_hang  = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         eng_armed     = 1'b0;
         eng_cnt       = 0;
         ifc.draw_done = 1'b0;
      end else if (ifc.draw_start) begin
         eng_armed = 1'b1;
         eng_cnt   = 0;
         eng_hang  = (ifc.draw_img == 8'hEE);
      end else if (eng_armed) begin
         eng_cnt++;
         if (eng_cnt == 1) ifc.draw_done = 1'b0;
         if (!eng_hang && eng_cnt >= eng_delay) begin
            ifc.draw_done = 1'b1;
            eng_armed     = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic write_entry(input int idx, input logic v, input logic [18:0] c, input logic [7:0] im);
      @(negedge clk);
      tbl_we     = 1'b1;
      tbl_waddr  = IDX_W'(idx);
      tbl_wvalid = v;
      tbl_wcoord = c;
      tbl_wimg   = im;
      @(negedge clk);
      tbl_we = 1'b0;
      mdl_valid[idx] = v;
      mdl_coord[idx] = c;
      mdl_img[idx]   = im;
   endtask

   task automatic clear_table();
      for (int i = 0; i < NUM_SPRITES; i++)
         if (mdl_valid[i]) write_entry(i, 1'b0, 19'd0, 8'd0);
   endtask

   // Ends at the negedge in the cycle after frame_start was sampled
   task automatic pulse_frame();
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic pulse_err_clr();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   // cyc counts from 1 at the negedge following the frame_start sample edge
   task automatic wait_frame_done(input int budget, output int cyc);
      cyc = 1;
      while (!frame_done && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      check("frame_done_seen", frame_done, 1);
   endtask

   task automatic wait_start(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ifc.draw_start && n < budget);
      check("draw_start_seen", ifc.draw_start, 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_sprites"}, sprites_drawn, 0);
      check({tag, "_timeout_err"}, timeout_err, 0);
      check({tag, "_overrun"}, frame_overrun, 0);
      check({tag, "_draw_start"}, ifc.draw_start, 0);
      check({tag, "_draw_coord"}, ifc.draw_coord, 0);
      check({tag, "_draw_img"}, ifc.draw_img, 0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int cyc;
      int starts0, fdone0, nvalid;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         mdl_valid[i] = 1'b0;
         mdl_coord[i] = '0;
         mdl_img[i]   = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // Empty table: 16 scan cycles then frame_done, no commands
      build_expected();
      starts0 = n_starts;
      pulse_frame();
      wait_frame_done(100, cyc);
      check("empty_frame_done_latency", cyc, NUM_SPRITES + 1);
      check("empty_sprites", sprites_drawn, 0);
      @(negedge clk);
      check("empty_busy_after", busy, 0);
      check("empty_frame_done_width", frame_done, 0);
      check("empty_no_starts", n_starts - starts0, 0);

      // Entries 0, 5, 15 drawn in order
      eng_delay = 70;
      write_entry(0, 1'b1, 19'h00100, 8'h01);
      write_entry(5, 1'b1, 19'h12345, 8'h22);
      write_entry(15, 1'b1, 19'h7FFFF, 8'hFF);
      build_expected();
      fdone0 = n_fdone;
      pulse_frame();
      check("busy_in_sweep", busy, 1);
      @(negedge clk);
      check("first_start_latency", ifc.draw_start, 1);
      wait_frame_done(1000, cyc);
      check("three_sprites", sprites_drawn, 3);
      @(negedge clk);
      check("three_frame_done_once", n_fdone - fdone0, 1);
      check("three_queue_empty", exp_q.size(), 0);
      repeat (5) @(negedge clk);
      check("three_sprites_hold", sprites_drawn, 3);

      // Done still high from the last draw: only a new edge completes
      clear_table();
      write_entry(7, 1'b1, 19'h0ABCD, 8'h44);
      eng_delay = 30;
      build_expected();
      pulse_frame();
      wait_start(50);
      repeat (10) @(negedge clk);
      check("stale_no_early_count", sprites_drawn, 0);
      check("stale_still_busy", busy, 1);
      wait_frame_done(200, cyc);
      check("stale_sprites", sprites_drawn, 1);

      // Entry 3 never completes: watchdog fires after TIMEOUT wait cycles
      clear_table();
      eng_delay = 5;
      write_entry(1, 1'b1, 19'h01111, 8'h11);
      write_entry(3, 1'b1, 19'h03333, 8'hEE);
      write_entry(6, 1'b1, 19'h06666, 8'h33);
      build_expected();
      pulse_frame();
      wait_start(50);
      wait_start(50);
      check("hang_img", ifc.draw_img, 8'hEE);
      cyc = 0;
      while (!timeout_err && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check("timeout_latency", cyc, TIMEOUT + 1);
      wait_frame_done(200, cyc);
      check("timeout_sprites", sprites_drawn, 2);
      check("timeout_sticky", timeout_err, 1);
      check("timeout_no_overrun", frame_overrun, 0);
      pulse_err_clr();
      check("timeout_cleared", timeout_err, 0);

      // Overrun during WAIT, write to in-flight and to a later entry
      clear_table();
      eng_delay = 40;
      write_entry(2, 1'b1, 19'h02222, 8'h52);
      write_entry(9, 1'b1, 19'h09999, 8'h59);
      build_expected();
      fdone0 = n_fdone;
      pulse_frame();
      wait_start(50);
      repeat (3) @(negedge clk);
      pulse_frame();
      check("overrun_set", frame_overrun, 1);
      write_entry(2, 1'b1, 19'h05555, 8'h77);
      check("inflight_coord_snapshot", ifc.draw_coord, 19'h02222);
      check("inflight_img_snapshot", ifc.draw_img, 8'h52);
      write_entry(9, 1'b1, 19'h0CAFE, 8'h9A);
      exp_q.delete();
      exp_q.push_back({19'h0CAFE, 8'h9A});
      wait_frame_done(500, cyc);
      check("overrun_sprites", sprites_drawn, 2);
      repeat (20) @(negedge clk);
      check("overrun_single_sweep", n_fdone - fdone0, 1);
      check("overrun_idle", busy, 0);
      pulse_err_clr();
      check("overrun_cleared", frame_overrun, 0);

      // Reset in the middle of WAIT
      clear_table();
      eng_delay = 100;
      write_entry(4, 1'b1, 19'h04444, 8'h64);
      build_expected();
      pulse_frame();
      wait_start(50);
      repeat (3) @(negedge clk);
      pulse_frame();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_all_zero("midreset");
      exp_q.delete();
      for (int i = 0; i < NUM_SPRITES; i++) mdl_valid[i] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      starts0 = n_starts;
      build_expected();
      pulse_frame();
      wait_frame_done(100, cyc);
      check("post_reset_latency", cyc, NUM_SPRITES + 1);
      check("post_reset_sprites", sprites_drawn, 0);
      check("post_reset_no_starts", n_starts - starts0, 0);

      // Randomized tables and engine delays
      for (int s = 0; s < 4; s++) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            logic [7:0] im;
            im = 8'($urandom_range(0, 255));
            if (im == 8'hEE) im = 8'h01;
            write_entry(i, ($urandom_range(0, 2) == 0), 19'($urandom), im);
         end
         eng_delay = $urandom_range(2, 25);
         nvalid = model_count();
         build_expected();
         pulse_frame();
         wait_frame_done(2000, cyc);
         check("rand_sprites", sprites_drawn, nvalid);
         check("rand_queue_empty", exp_q.size(), 0);
         check("rand_no_timeout", timeout_err, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
